// File: rtl/riscv_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes, queue entry type,
// and load data extension.
package riscv_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Unknown funct3 codes fall back to a full-word load.
  function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                              input logic [1:0]  offset,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNCT3_LB:  r = {{24{b[7]}}, b};
      FUNCT3_LH:  r = {{16{h[15]}}, h};
      FUNCT3_LW:  r = word;
      FUNCT3_LBU: r = {24'h0, b};
      FUNCT3_LHU: r = {16'h0, h};
      default:    r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// ALU/load result inputs and register-file write outputs of the writeback stage.
interface writeback_stage_if #(parameter int DEPTH = 2);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_AluValid;
  logic [4:0]    i_AluRegDest;
  logic [31:0]   i_AluData;
  logic          i_LoadValid;
  logic          o_LoadReady;
  logic [4:0]    i_LoadRegDest;
  logic [2:0]    i_LoadFunct3;
  logic [1:0]    i_LoadByteOffset;
  logic [31:0]   i_LoadWord;
  logic          o_WriteEnable;
  logic [4:0]    o_RegDest;
  logic [31:0]   o_DataOut;
  logic [CW-1:0] o_QueueCount;

  modport master (
    output i_AluValid, i_AluRegDest, i_AluData,
    output i_LoadValid, i_LoadRegDest, i_LoadFunct3, i_LoadByteOffset, i_LoadWord,
    input  o_LoadReady, o_WriteEnable, o_RegDest, o_DataOut, o_QueueCount
  );

  modport slave (
    input  i_AluValid, i_AluRegDest, i_AluData,
    input  i_LoadValid, i_LoadRegDest, i_LoadFunct3, i_LoadByteOffset, i_LoadWord,
    output o_LoadReady, o_WriteEnable, o_RegDest, o_DataOut, o_QueueCount
  );

endinterface

// File: rtl/wb_load_queue.sv
// Ordered load-result buffer: push at tail, pop oldest, squash every entry matching an rd.
// Survivors are compacted toward slot 0 each cycle, so squash holes never delay a pop.
module wb_load_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  input  logic          push_i,
  input  wb_entry_t     push_entry_i,
  input  logic          pop_i,
  input  logic          squash_i,
  input  logic [4:0]    squash_rd_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  wb_entry_t     q_q [DEPTH];
  wb_entry_t     q_d [DEPTH];
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    logic [CW-1:0] cnt;
    logic          keep;
    cnt = '0;
    for (int j = 0; j < DEPTH; j++) q_d[j] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keep = q_q[i].valid && !(pop_i && i == 0) &&
             !(squash_i && q_q[i].rd == squash_rd_i);
      if (keep) begin
        for (int j = 0; j < DEPTH; j++)
          if (cnt == CW'(j)) q_d[j] = q_q[i];
        cnt = cnt + CW'(1);
      end
    end
    if (push_i) begin
      for (int j = 0; j < DEPTH; j++)
        if (cnt == CW'(j)) q_d[j] = push_entry_i;
      cnt = cnt + CW'(1);
    end
    count_d = cnt;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      count_q <= count_d;
    end
  end

  assign head_o  = q_q[0];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/writeback_stage.sv
// Merges ALU and load results onto the single register-file write port with one cycle of
// latency; ALU has strict priority, colliding loads wait in a small queue.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int LOAD_QUEUE_DEPTH = 2
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  writeback_stage_if.slave  wb
);

  localparam int CW = $clog2(LOAD_QUEUE_DEPTH) + 1;

  logic          alu_win, load_acc, load_live, q_pop, q_push, bypass, q_full;
  wb_entry_t     load_entry, q_head;
  logic [CW-1:0] q_count;

  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;

  assign alu_win  = wb.i_AluValid && (wb.i_AluRegDest != 5'd0);
  assign load_acc = wb.i_LoadValid && !q_full;

  // A same-cycle ALU write to the same rd is younger, so the load is dropped.
  assign load_live = load_acc && (wb.i_LoadRegDest != 5'd0) &&
                     !(alu_win && wb.i_LoadRegDest == wb.i_AluRegDest);
  assign q_pop     = !alu_win && q_head.valid;
  assign bypass    = !alu_win && !q_head.valid && load_live;
  assign q_push    = load_live && !bypass;

  always_comb begin
    load_entry       = '0;
    load_entry.valid = 1'b1;
    load_entry.rd    = wb.i_LoadRegDest;
    load_entry.data  = load_extend(wb.i_LoadFunct3, wb.i_LoadByteOffset, wb.i_LoadWord);
  end

  wb_load_queue #(.DEPTH(LOAD_QUEUE_DEPTH), .CW(CW)) u_queue (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .push_i       (q_push),
    .push_entry_i (load_entry),
    .pop_i        (q_pop),
    .squash_i     (alu_win),
    .squash_rd_i  (wb.i_AluRegDest),
    .head_o       (q_head),
    .count_o      (q_count),
    .full_o       (q_full)
  );

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (alu_win) begin
      we_d   = 1'b1;
      rd_d   = wb.i_AluRegDest;
      data_d = wb.i_AluData;
    end else if (q_pop) begin
      we_d   = 1'b1;
      rd_d   = q_head.rd;
      data_d = q_head.data;
    end else if (bypass) begin
      we_d   = 1'b1;
      rd_d   = load_entry.rd;
      data_d = load_entry.data;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= 32'd0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign wb.o_WriteEnable = we_q;
  assign wb.o_RegDest     = rd_q;
  assign wb.o_DataOut     = data_q;
  assign wb.o_QueueCount  = q_count;
  assign wb.o_LoadReady   = !q_full;

endmodule
